// File: rtl/processor_alu.sv
// processor_alu
//   Combinational 16-bit ALU with a zero flag.
//   The flag is live during ADD/SUB. For every other opcode it comes from a
//   register that was last written by an ADD/SUB.
//
// Ports
//   clk     in   1   processor clock; the flag register samples on the rising edge
//   rst_n   in   1   async active-low reset; clears the flag register only
//   A       in  16   operand A (unsigned)
//   B       in  16   operand B (unsigned)
//   select  in   3   opcode: 000 ADD, 001 SUB (B-A), 010 MUL (low 16 bits),
//                    011 PASSA, 100 PASSB, 101..111 reserved (result 0)
//   out     out 16   result, purely combinational
//   z_flag  out  1   zero flag
module processor_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [2:0]  select,
  output logic [15:0] out,
  output logic        z_flag
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_MUL   = 3'b010,
    OP_PASSA = 3'b011,
    OP_PASSB = 3'b100
  } op_e;

  logic zero_now;
  logic is_arith;
  logic z_reg;

  // All arithmetic is modulo 2^16.
  // Carries, borrows and the high product bits fall off the 16-bit assignment.
  always_comb begin
    out = 16'h0000;
    case (select)
      OP_ADD:   out = A + B;
      OP_SUB:   out = B - A;   // B is the minuend
      OP_MUL:   out = A * B;
      OP_PASSA: out = A;
      OP_PASSB: out = B;
      default:  out = 16'h0000;
    endcase
  end

  assign zero_now = (out == 16'h0000);
  assign is_arith = (select == OP_ADD) || (select == OP_SUB);

  // Only ADD/SUB update the flag.
  // Every other opcode leaves the last arithmetic result's flag visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        z_reg <= 1'b0;
    else if (is_arith) z_reg <= zero_now;
  end

  assign z_flag = is_arith ? zero_now : z_reg;

endmodule

// File: tb/tb_processor_alu.sv
module tb_processor_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A, B;
  logic [2:0]  select;
  logic [15:0] out;
  logic        z_flag;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit mdl_z  = 1'b0;   // model of the stored flag

  processor_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .select (select),
    .out    (out),
    .z_flag (z_flag)
  );

  always #5 clk = ~clk;

  // Reference result, computed with plain integer arithmetic.
  function automatic logic [15:0] ref_out(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] s);
    longint unsigned ua = a, ub = b, r;
    case (s)
      3'd0:    r = (ua + ub) % 65536;
      3'd1:    r = (ub + 65536 - ua) % 65536;
      3'd2:    r = (ua * ub) % 65536;
      3'd3:    r = ua;
      3'd4:    r = ub;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic bit ref_z(input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] s, input bit zstored);
    if (s == 3'd0 || s == 3'd1) return (ref_out(a, b, s) == 16'h0000);
    return zstored;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (A=%0h B=%0h sel=%0d rst_n=%0b)",
               name, got, exp, A, B, select, rst_n);
    end
  endtask

  // The stored flag captures zero-ness of ADD/SUB at each rising edge.
  // Reset clears it immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl_z = 1'b0;
    else if (select == 3'd0 || select == 3'd1)
      mdl_z = (ref_out(A, B, select) == 16'h0000);
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out", {16'h0, out}, {16'h0, ref_out(A, B, select)});
      check("cyc_z", {31'h0, z_flag}, {31'h0, ref_z(A, B, select, mdl_z)});
    end
  end

  // Drive new inputs 1 ns after a rising edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    @(posedge clk);
    #1;
    A = a; B = b; select = s;
  endtask

  // Directed checks with hand-computed values, taken 1 ns after the inputs settle.
  task automatic dir(input string name, input logic [15:0] eo, input bit chk_z, input bit ez);
    #1;
    check({name, "_out"}, {16'h0, out}, {16'h0, eo});
    if (chk_z) check({name, "_z"}, {31'h0, z_flag}, {31'h0, ez});
  endtask

  initial begin
    rst_n = 1'b0; A = 16'h0; B = 16'h0; select = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", {31'h0, z_flag}, 32'h0);
    check("rst_out", {16'h0, out}, 32'h0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    drive(16'd60, 16'd62, 3'd0);        dir("add", 16'd122, 1, 0);
    drive(16'd20, 16'd40, 3'd1);        dir("sub", 16'd20, 1, 0);
    drive(16'd40, 16'd40, 3'd1);        dir("sub_zero", 16'd0, 1, 1);
    drive(16'd1, 16'd0, 3'd1);          dir("sub_wrap", 16'hFFFF, 1, 0);
    drive(16'd40, 16'd40, 3'd2);        dir("mul", 16'd1600, 1, 0);
    // A truncated product of zero must not set the flag.
    drive(16'h0100, 16'h0100, 3'd2);    dir("mul_trunc", 16'd0, 1, 0);

    // Flag hold: a clocked SUB of equal operands stores 1.
    drive(16'd40, 16'd40, 3'd1);
    drive(16'd40, 16'd20, 3'd3);        dir("passa", 16'd40, 1, 1);
    drive(16'd40, 16'd20, 3'd4);        dir("passb", 16'd20, 1, 1);
    drive(16'd40, 16'd20, 3'd7);        dir("rsvd7", 16'd0, 1, 1);
    drive(16'd40, 16'd20, 3'd5);        dir("rsvd5", 16'd0, 1, 1);

    // Reset mid-cycle under MUL drops the flag at once; out is unaffected.
    drive(16'd40, 16'd20, 3'd2);        dir("pre_rst", 16'd800, 1, 1);
    rst_n = 1'b0;
    dir("mid_rst", 16'd800, 1, 0);
    select = 3'd1;                      dir("rst_sub", 16'hFFEC, 1, 0);
    A = 16'd20;                         dir("rst_sub0", 16'd0, 1, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    A = 16'd0; B = 16'd0; select = 3'd0; dir("add00", 16'd0, 1, 1);
    drive(16'd5, 16'd0, 3'd3);          dir("hold_after", 16'd5, 1, 1);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: begin ra = 16'h0; rb = 16'h0; end
        2: rb = 16'(16'h0 - ra);
        3: begin ra = 16'(1 << $urandom_range(0, 15)); rb = 16'(1 << $urandom_range(0, 15)); end
        default: ;
      endcase
      drive(ra, rb, 3'($urandom_range(0, 7)));
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 24) == 0) begin
        #2;
        rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
